// File: rtl/gif_frame_fetch_if.sv
// gif_frame_fetch_if: SDRAM master bus plus pixel stream bundle for gif_frame_fetch
// master: frame fetcher (drives if_address/if_read/..., pix_data/pix_valid/pix_sof/pix_eol)
// slave:  memory interface and pixel consumer (drive if_acknowledge/if_read_data, pix_ready)
interface gif_frame_fetch_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 128,
  parameter int PIX_W  = 16
);
  logic [ADDR_W-1:0]   if_address;
  logic [DATA_W/8-1:0] if_byte_enable;
  logic                if_read;
  logic                if_write;
  logic [DATA_W-1:0]   if_write_data;
  logic                if_acknowledge;
  logic [DATA_W-1:0]   if_read_data;
  logic [PIX_W-1:0]    pix_data;
  logic                pix_valid;
  logic                pix_ready;
  logic                pix_sof;
  logic                pix_eol;
  modport master (
    output if_address, if_byte_enable, if_read, if_write, if_write_data,
    input  if_acknowledge, if_read_data,
    output pix_data, pix_valid, pix_sof, pix_eol,
    input  pix_ready
  );
  modport slave (
    input  if_address, if_byte_enable, if_read, if_write, if_write_data,
    output if_acknowledge, if_read_data,
    input  pix_data, pix_valid, pix_sof, pix_eol,
    output pix_ready
  );
endinterface

// File: rtl/gif_frame_fetch.sv
// gif_frame_fetch: reads one GIF frame from SDRAM (128-bit words) and streams it as 16-bit pixels
// clk, reset_n (async, active low); frame_start pulse with frame_idx/image_idx selects the frame slot
// busy/frame_done report progress; stall_count counts consumer-ready cycles with no pixel
// bus (master modport): SDRAM read port and pixel stream with sof/eol markers
// Optional GIF_FETCH_STATS_EN enables stall_count, otherwise it is tied to 0
module gif_frame_fetch #(
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 128,
  parameter int PIX_W       = 16,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int FRAME_SHIFT = 20,
  parameter int IMAGE_SHIFT = 23,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic [7:0]        frame_idx,
  input  logic [7:0]        image_idx,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       stall_count,
  gif_frame_fetch_if.master bus
);
  localparam int WORDS = H_ACTIVE * V_ACTIVE / 8;
  localparam int NW    = $clog2(WORDS);
  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = $clog2(V_ACTIVE);
  localparam int PW    = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NW-1:0]     word_q;
  logic              rd_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q;
  logic [PW-1:0]     rp_q;
  logic [PW:0]       cnt_q;
  logic [PW:0]       cnt_d;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              valid;
  logic              accept;
  logic              ack;
  logic              pop;
  logic              last_x;
  logic              last_pix;
  logic              start_ok;
  logic [ADDR_W-1:0] base;
  assign valid    = cnt_q != '0;
  assign accept   = valid & bus.pix_ready;
  assign ack      = rd_q & bus.if_acknowledge;
  // a word leaves the FIFO once its eighth pixel is taken; x low bits select the pixel
  assign pop      = accept & (x_q[2:0] == 3'd7);
  assign last_x   = x_q == XW'(H_ACTIVE - 1);
  assign last_pix = accept & last_x & (y_q == YW'(V_ACTIVE - 1));
  assign start_ok = (state_q == IDLE) & frame_start;
  assign cnt_d    = cnt_q + (PW+1)'(ack) - (PW+1)'(pop);
  assign base     = (ADDR_W'(image_idx) << IMAGE_SHIFT) + (ADDR_W'(frame_idx) << FRAME_SHIFT);
  assign bus.if_address     = addr_q;
  assign bus.if_byte_enable = '1;
  assign bus.if_read        = rd_q;
  assign bus.if_write       = 1'b0;
  assign bus.if_write_data  = '0;
  assign bus.pix_valid      = valid;
  assign bus.pix_data       = valid ? mem_q[rp_q][PIX_W*int'(x_q[2:0]) +: PIX_W] : '0;
  assign bus.pix_sof        = valid & (x_q == '0) & (y_q == '0);
  assign bus.pix_eol        = valid & last_x;
  assign busy               = busy_q;
  assign frame_done         = done_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE:
          if (start_ok) begin
            state_q <= FETCH;
            addr_q  <= base;
            word_q  <= '0;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        FETCH: begin
          if (ack) begin
            addr_q <= addr_q + ADDR_W'(DATA_W / 8);
            word_q <= word_q + NW'(1);
          end
          // one read in flight at most, so a new read needs a free slot after this cycle's push/pop
          if (ack && word_q == NW'(WORDS - 1)) begin
            state_q <= DRAIN;
            rd_q    <= 1'b0;
          end else if (ack || !rd_q)
            rd_q <= cnt_d < (PW+1)'(FIFO_DEPTH);
        end
        DRAIN:
          if (last_pix) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        default: state_q <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (ack) mem_q[wp_q] <= bus.if_read_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      if (ack) wp_q <= wp_q + PW'(1);
      if (pop) rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_d;
      if (accept) begin
        x_q <= last_x ? '0 : x_q + XW'(1);
        if (last_x) y_q <= (y_q == YW'(V_ACTIVE - 1)) ? '0 : y_q + YW'(1);
      end
    end
`ifdef GIF_FETCH_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) stall_q <= '0;
    else if (start_ok) stall_q <= '0;
    else if (busy_q & bus.pix_ready & !valid & (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif
endmodule
